// File: rtl/out_display_pkg.sv
// Shared constants for the hex display driver: widths, the hex-to-segment
// code table (active-low, bit 0 = segment a) and the blank code.
package out_display_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned UPD_W  = 16;
  localparam int unsigned IDX_W  = 2;
  localparam int unsigned SEG_W  = 7;
  localparam int unsigned AN_W   = 4;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

  // Glyphs 0..F, segments g..a, active-low
  localparam logic [SEG_W-1:0] HEX_SEG [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

endpackage

// File: rtl/out_display_hex7seg.sv
// Combinational nibble-to-glyph decoder.
module hex7seg
  import out_display_pkg::*;
(
  input  logic [3:0]       nibble,
  output logic [SEG_W-1:0] seg_c
);

  assign seg_c = HEX_SEG[nibble];

endmodule

// File: rtl/out_display.sv
// Four-digit multiplexed hex display for the CPU output word, with optional
// leading-zero blanking and a decimal-point "recently updated" indicator.
module out_display
  import out_display_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 1024,
  parameter int unsigned BLANK_LZ = 1,
  parameter int unsigned UPD_HOLD = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data,
  input  logic              load,
  output logic [AN_W-1:0]   an,
  output logic [SEG_W-1:0]  seg,
  output logic              dp
);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] shown_q, shown_d;
  logic [UPD_W-1:0]  upd_q, upd_d;

  logic [AN_W-1:0]   an_d;
  logic [SEG_W-1:0]  seg_d;
  logic              dp_d;

  logic [DATA_W-1:0] upper_c;
  logic [3:0]        nib_c;
  logic [SEG_W-1:0]  glyph_c;
  logic              blank_c;

  // Scan timing, captured value and update-hold countdown
  always_comb begin
    cnt_d   = cnt_q + CNT_W'(1);
    idx_d   = idx_q;
    shown_d = shown_q;
    upd_d   = upd_q;
    if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
      cnt_d = '0;
      idx_d = idx_q + IDX_W'(1);
    end
    if (load && (data != shown_q)) begin
      shown_d = data;
      upd_d   = UPD_W'(UPD_HOLD);
    end else if (upd_q != '0) begin
      upd_d = upd_q - UPD_W'(1);
    end
  end

  // Selected nibble and everything above it, for leading-zero detection
  always_comb begin
    upper_c = shown_q >> {idx_q, 2'b00};
    nib_c   = upper_c[3:0];
    blank_c = (BLANK_LZ != 0) && (idx_q != '0) && (upper_c == '0);
  end

  hex7seg u_hex7seg (
    .nibble (nib_c),
    .seg_c  (glyph_c)
  );

  // Next output values from the current digit index and display state
  always_comb begin
    an_d  = ~(AN_W'(1) << idx_q);
    seg_d = blank_c ? SEG_BLANK : glyph_c;
    dp_d  = !((idx_q == '0) && (upd_q != '0));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      shown_q <= '0;
      upd_q   <= '0;
      an      <= '1;
      seg     <= SEG_BLANK;
      dp      <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shown_q <= shown_d;
      upd_q   <= upd_d;
      an      <= an_d;
      seg     <= seg_d;
      dp      <= dp_d;
    end
  end

endmodule
